seg_reader: RTL and testbench
=============================

SEG_READER -- requirements
Module: seg_reader

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 4, range 2..255; consecutive identical samples required to accept a pattern.
REQ-002 SHALL have port clk  input  1  the single clock; all logic on rising edge.
REQ-003 SHALL have port rst  input  1  synchronous, active-high reset.
REQ-004 SHALL have port seg_in  input  7  active-low segment bus: bit6=g … bit0=a; asynchronous to pattern changes.
REQ-005 SHALL have port digit_out  output  4  decoded digit 0..9; 4'hF when no valid digit is held.
REQ-006 SHALL have port digit_valid  output  1  high while the accepted pattern is a legal digit.
REQ-007 SHALL have port blank  output  1  high while the accepted pattern is 7'b111_1111.
REQ-008 SHALL have port err  output  1  high while the accepted pattern is neither a digit nor blank.
REQ-009 SHALL have port new_pulse  output  1  one-cycle strobe when the accepted pattern changes.

Function
REQ-010 SHALL register seg_in once (sample stage) before any comparison.
REQ-011 SHALL decode the legal codes 0=100_0000, 1=111_1001, 2=010_0100, 3=011_0000, 4=001_1001, 5=001_0010, 6=000_0010, 7=111_1000, 8=000_0000, 9=001_0000.
REQ-012 SHALL implement the FSM states EMPTY (nothing accepted), SETTLE (candidate counting) and LOCKED (accepted pattern stable).
REQ-013 SHALL transition EMPTY->SETTLE on the first sample after reset and load the candidate, with run count = 1.
REQ-014 SHALL, in SETTLE, increment the run count when the sample equals the candidate, or reload the candidate with run count = 1 when it differs.
REQ-015 SHALL accept the candidate and move SETTLE->LOCKED at the edge where the run count reaches STABLE_CYCLES.
REQ-016 SHALL update the outputs at that same edge, giving a total latency of STABLE_CYCLES+1 edges from a seg_in change to the output change.
REQ-017 SHALL, in LOCKED, stay LOCKED on a sample equal to the accepted pattern, or go to SETTLE with the new candidate on a differing sample.
REQ-018 SHALL keep all outputs except new_pulse holding the last accepted values throughout SETTLE; a glitch shorter than STABLE_CYCLES SHALL produce no output change.
REQ-019 SHALL, when the candidate equals the already-accepted pattern after settling, return to LOCKED without asserting new_pulse.
REQ-020 SHALL assert new_pulse for exactly one cycle, coincident with the output update, only when the accepted pattern differs from the previous one or on the first acceptance after reset.
REQ-021 SHALL keep digit_valid, blank and err mutually exclusive, with at most one high.
REQ-022 SHALL drive digit_out = 4'hF whenever digit_valid = 0.
REQ-023 SHALL saturate the run counter at STABLE_CYCLES, so no wrap occurs under an indefinitely stable input.

Reset
REQ-024 SHALL, on rst=1 at a clock edge, enter EMPTY, clear the candidate and run count, and drive digit_out=4'hF, digit_valid=0, blank=0, err=0, new_pulse=0.
REQ-025 SHALL take reset priority over any in-progress settle, with the discarded candidate producing no new_pulse.

Configuration
REQ-026 SHALL, with macro SEG_READER_ERRCNT_EN defined, add output err_cnt (8 bits) counting accepted illegal patterns, saturating at 255 and cleared by rst.
REQ-027 SHALL, without SEG_READER_ERRCNT_EN, have no err_cnt port and no counter logic; all other behaviour SHALL be identical.

Structure
REQ-028 SHALL keep the segment code constants SEG_0..SEG_9 and SEG_BLANK, and the FSM state typedef, in shared package elevator_pkg.
REQ-029 SHALL implement pattern-to-digit lookup in the combinational sub-module seg_pattern_lut (in: 7-bit pattern; out: digit, is_digit, is_blank).

Verification (STABLE_CYCLES=4)
REQ-030 SHALL cover: reset, then hold seg_in=010_0100 -> after 5 edges digit_out=2, digit_valid=1, and new_pulse high for 1 cycle.
REQ-031 SHALL cover: locked on 2, then 3-cycle glitch to 011_0000 and back -> digit_out stays 2, with no new_pulse.
REQ-032 SHALL cover: locked on 2, then hold 111_1111 -> after 5 edges blank=1, digit_valid=0, digit_out=F, and one new_pulse.
REQ-033 SHALL cover: hold 111_1110 -> err=1, digit_out=F, and err_cnt=1 when SEG_READER_ERRCNT_EN is set.
REQ-034 SHALL cover: assert rst during SETTLE (2 samples of 001_0000) -> all reset values next edge, and no new_pulse.
REQ-035 SHALL cover: sweep all 10 digit codes, each held 6 cycles -> digit_out matches 0..9 in order, with exactly 10 new_pulses.

Source files
------------

// File: rtl/elevator_pkg.sv
// Shared segment codes (active-low, bit6=g .. bit0=a) and reader FSM state type.
package elevator_pkg;

   localparam logic [6:0] SEG_0     = 7'b100_0000;
   localparam logic [6:0] SEG_1     = 7'b111_1001;
   localparam logic [6:0] SEG_2     = 7'b010_0100;
   localparam logic [6:0] SEG_3     = 7'b011_0000;
   localparam logic [6:0] SEG_4     = 7'b001_1001;
   localparam logic [6:0] SEG_5     = 7'b001_0010;
   localparam logic [6:0] SEG_6     = 7'b000_0010;
   localparam logic [6:0] SEG_7     = 7'b111_1000;
   localparam logic [6:0] SEG_8     = 7'b000_0000;
   localparam logic [6:0] SEG_9     = 7'b001_0000;
   localparam logic [6:0] SEG_BLANK = 7'b111_1111;

   typedef enum logic [1:0] {EMPTY, SETTLE, LOCKED} rd_state_t;

endpackage

// File: rtl/seg_pattern_lut.sv
// Combinational 7-segment pattern to digit lookup; digit is 4'hF for non-digits.
module seg_pattern_lut
   import elevator_pkg::*;
(
   input  logic [6:0] pattern,
   output logic [3:0] digit,
   output logic       is_digit,
   output logic       is_blank
);

   always_comb begin
      digit    = 4'hF;
      is_digit = 1'b1;
      is_blank = 1'b0;
      case (pattern)
         SEG_0:     digit = 4'd0;
         SEG_1:     digit = 4'd1;
         SEG_2:     digit = 4'd2;
         SEG_3:     digit = 4'd3;
         SEG_4:     digit = 4'd4;
         SEG_5:     digit = 4'd5;
         SEG_6:     digit = 4'd6;
         SEG_7:     digit = 4'd7;
         SEG_8:     digit = 4'd8;
         SEG_9:     digit = 4'd9;
         SEG_BLANK: begin is_digit = 1'b0; is_blank = 1'b1; end
         default:   is_digit = 1'b0;
      endcase
   end

endmodule

// File: rtl/seg_reader.sv
// Debounced 7-segment display reader: a pattern is accepted after STABLE_CYCLES
// identical samples. Define SEG_READER_ERRCNT_EN to add the err_cnt output.
module seg_reader
   import elevator_pkg::*;
#(
   parameter int STABLE_CYCLES = 4
)(
   input  logic       clk,
   input  logic       rst,
   input  logic [6:0] seg_in,
   output logic [3:0] digit_out,
   output logic       digit_valid,
   output logic       blank,
   output logic       err,
   output logic       new_pulse
`ifdef SEG_READER_ERRCNT_EN
   ,
   output logic [7:0] err_cnt
`endif
);

   localparam logic [7:0] STABLE = 8'(STABLE_CYCLES);

   rd_state_t  state;
   logic [6:0] smp, cand, acc;
   logic       smp_vld, has_acc;
   logic [7:0] run, run_nxt;
   logic [3:0] lut_digit;
   logic       lut_is_digit, lut_is_blank;

   seg_pattern_lut u_lut (
      .pattern  (cand),
      .digit    (lut_digit),
      .is_digit (lut_is_digit),
      .is_blank (lut_is_blank)
   );

   assign run_nxt = (run == STABLE) ? run : run + 8'd1;

   always_ff @(posedge clk) begin
      if (rst) begin
         state       <= EMPTY;
         smp         <= '0;
         smp_vld     <= 1'b0;
         cand        <= '0;
         acc         <= '0;
         has_acc     <= 1'b0;
         run         <= '0;
         digit_out   <= 4'hF;
         digit_valid <= 1'b0;
         blank       <= 1'b0;
         err         <= 1'b0;
         new_pulse   <= 1'b0;
`ifdef SEG_READER_ERRCNT_EN
         err_cnt     <= '0;
`endif
      end else begin
         smp       <= seg_in;
         smp_vld   <= 1'b1;
         new_pulse <= 1'b0;
         case (state)
            // smp_vld keeps the reset value of smp out of the first candidate
            EMPTY: if (smp_vld) begin
               cand  <= smp;
               run   <= 8'd1;
               state <= SETTLE;
            end
            SETTLE: if (smp == cand) begin
               run <= run_nxt;
               if (run_nxt == STABLE) begin
                  state <= LOCKED;
                  if (!has_acc || cand != acc) begin
                     acc         <= cand;
                     has_acc     <= 1'b1;
                     new_pulse   <= 1'b1;
                     digit_out   <= lut_digit;
                     digit_valid <= lut_is_digit;
                     blank       <= lut_is_blank;
                     err         <= !lut_is_digit && !lut_is_blank;
`ifdef SEG_READER_ERRCNT_EN
                     if (!lut_is_digit && !lut_is_blank && err_cnt != 8'hFF)
                        err_cnt <= err_cnt + 8'd1;
`endif
                  end
               end
            end else begin
               cand <= smp;
               run  <= 8'd1;
            end
            LOCKED: if (smp == acc) begin
               run <= run_nxt;
            end else begin
               cand  <= smp;
               run   <= 8'd1;
               state <= SETTLE;
            end
            default: state <= EMPTY;
         endcase
      end
   end

endmodule

// File: tb/tb_seg_reader.sv
// Directed bench for seg_reader (STABLE_CYCLES=4): table sweep plus hand sequences.
module tb_seg_reader;
   import elevator_pkg::*;

   logic       clk = 1'b0;
   logic       rst;
   logic [6:0] seg_in;
   logic [3:0] digit_out;
   logic       digit_valid, blank, err, new_pulse;
`ifdef SEG_READER_ERRCNT_EN
   logic [7:0] err_cnt;
`endif

   int pass_cnt = 0;
   int total    = 0;
   int pulses   = 0;

   typedef struct packed {
      logic [6:0] seg;
      logic [3:0] digit;
      logic       valid;
      logic       bl;
      logic       er;
   } vec_t;

   vec_t tbl [13];

   seg_reader #(.STABLE_CYCLES(4)) dut (
      .clk         (clk),
      .rst         (rst),
      .seg_in      (seg_in),
      .digit_out   (digit_out),
      .digit_valid (digit_valid),
      .blank       (blank),
      .err         (err),
      .new_pulse   (new_pulse)
`ifdef SEG_READER_ERRCNT_EN
      ,
      .err_cnt     (err_cnt)
`endif
   );

   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
      if (new_pulse) pulses++;
   endtask

   task automatic chk(input string nm, input int act, input int exp);
      total++;
      if (act == exp) pass_cnt++;
      else $display("FAIL %s: got %0d expected %0d", nm, act, exp);
   endtask

   initial begin
      int sweep_pulses;
      bit stayed;

      tbl[0]  = '{SEG_0, 4'd0, 1'b1, 1'b0, 1'b0};
      tbl[1]  = '{SEG_1, 4'd1, 1'b1, 1'b0, 1'b0};
      tbl[2]  = '{SEG_2, 4'd2, 1'b1, 1'b0, 1'b0};
      tbl[3]  = '{SEG_3, 4'd3, 1'b1, 1'b0, 1'b0};
      tbl[4]  = '{SEG_4, 4'd4, 1'b1, 1'b0, 1'b0};
      tbl[5]  = '{SEG_5, 4'd5, 1'b1, 1'b0, 1'b0};
      tbl[6]  = '{SEG_6, 4'd6, 1'b1, 1'b0, 1'b0};
      tbl[7]  = '{SEG_7, 4'd7, 1'b1, 1'b0, 1'b0};
      tbl[8]  = '{SEG_8, 4'd8, 1'b1, 1'b0, 1'b0};
      tbl[9]  = '{SEG_9, 4'd9, 1'b1, 1'b0, 1'b0};
      tbl[10] = '{7'b111_1111, 4'hF, 1'b0, 1'b1, 1'b0};
      tbl[11] = '{7'b111_1110, 4'hF, 1'b0, 1'b0, 1'b1};
      tbl[12] = '{7'b000_0001, 4'hF, 1'b0, 1'b0, 1'b1};

      // reset state
      rst    = 1'b1;
      seg_in = 7'b111_1111;
      repeat (3) tick();
      chk("rst_digit", int'(digit_out), 15);
      chk("rst_valid", int'(digit_valid), 0);
      chk("rst_blank", int'(blank), 0);
      chk("rst_err", int'(err), 0);
      chk("rst_pulse", int'(new_pulse), 0);

      // first acceptance of 2: exactly 5 edges of latency
      rst    = 1'b0;
      seg_in = SEG_2;
      pulses = 0;
      repeat (4) tick();
      chk("lat4_digit", int'(digit_out), 15);
      chk("lat4_pulses", pulses, 0);
      tick();
      chk("lat5_digit", int'(digit_out), 2);
      chk("lat5_valid", int'(digit_valid), 1);
      chk("lat5_pulse", int'(new_pulse), 1);
      tick();
      chk("lat6_pulse", int'(new_pulse), 0);
      chk("lat6_pulses", pulses, 1);

      // 3-cycle glitch to 3 and back: no visible change
      seg_in = SEG_3;
      pulses = 0;
      stayed = 1'b1;
      repeat (3) begin
         tick();
         if (digit_out != 4'd2 || !digit_valid) stayed = 1'b0;
      end
      seg_in = SEG_2;
      repeat (8) begin
         tick();
         if (digit_out != 4'd2 || !digit_valid) stayed = 1'b0;
      end
      chk("glitch_hold", int'(stayed), 1);
      chk("glitch_pulses", pulses, 0);

      // blank
      seg_in = SEG_BLANK;
      pulses = 0;
      repeat (6) tick();
      chk("blank_blank", int'(blank), 1);
      chk("blank_valid", int'(digit_valid), 0);
      chk("blank_err", int'(err), 0);
      chk("blank_digit", int'(digit_out), 15);
      chk("blank_pulses", pulses, 1);

      // illegal pattern
      seg_in = 7'b111_1110;
      pulses = 0;
      repeat (6) tick();
      chk("err_err", int'(err), 1);
      chk("err_digit", int'(digit_out), 15);
      chk("err_blank", int'(blank), 0);
      chk("err_pulses", pulses, 1);
`ifdef SEG_READER_ERRCNT_EN
      chk("err_cnt1", int'(err_cnt), 1);
`endif

      // reset in the middle of settling on 9
      seg_in = SEG_9;
      repeat (2) tick();
      rst    = 1'b1;
      pulses = 0;
      tick();
      chk("rstset_digit", int'(digit_out), 15);
      chk("rstset_valid", int'(digit_valid), 0);
      chk("rstset_blank", int'(blank), 0);
      chk("rstset_err", int'(err), 0);
      chk("rstset_pulse", int'(new_pulse), 0);
`ifdef SEG_READER_ERRCNT_EN
      chk("rstset_errcnt", int'(err_cnt), 0);
`endif
      repeat (4) tick();
      chk("rstset_pulses", pulses, 0);

      // sweep of all codes, each held 6 cycles
      rst          = 1'b0;
      sweep_pulses = 0;
      for (int i = 0; i < 13; i++) begin
         seg_in = tbl[i].seg;
         pulses = 0;
         repeat (6) tick();
         chk($sformatf("sw%0d_digit", i), int'(digit_out), int'(tbl[i].digit));
         chk($sformatf("sw%0d_valid", i), int'(digit_valid), int'(tbl[i].valid));
         chk($sformatf("sw%0d_blank", i), int'(blank), int'(tbl[i].bl));
         chk($sformatf("sw%0d_err", i), int'(err), int'(tbl[i].er));
         chk($sformatf("sw%0d_pulses", i), pulses, 1);
         if (i < 10) sweep_pulses += pulses;
      end
      chk("sweep_digit_pulses", sweep_pulses, 10);
`ifdef SEG_READER_ERRCNT_EN
      chk("sweep_errcnt", int'(err_cnt), 2);
`endif

      $display("%0d/%0d checks passed", pass_cnt, total);
      $finish;
   end

endmodule
